// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RV32I core constants
// Purpose: data width, RV32I major opcodes used by fetch, decode and
// immediate generation, and the canonical NOP (addi x0, x0, 0).
// Ports: none (package).
package core_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
   localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
   localparam logic [6:0] OPC_STORE  = 7'b010_0011;
   localparam logic [6:0] OPC_BRANCH = 7'b110_0011;

   localparam logic [31:0] NOP_INSTR = {12'h000, 5'd0, 3'b000, 5'd0, OPC_OP_IMM};

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO holding fetched {pc, instr} pairs
// Purpose: small power-of-two deep buffer between instruction memory and decode.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   clear_i               drop all entries (wins over push/pop)
//   push_i, push_data_i   write one entry
//   pop_i                 remove the head entry
//   head_o                head entry (stale when empty; caller masks it)
//   count_o               number of stored entries, 0..DEPTH
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clear_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW:0]      count;

   assign head_o  = mem[rd_ptr];
   assign count_o = count;

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_i) wr_ptr <= wr_ptr + AW'(1);
         if (pop_i)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_i, pop_i})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; emptiness is tracked by count.
   always_ff @(posedge clk_i) begin
      if (push_i && !clear_i) mem[wr_ptr] <= push_data_i;
   end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - RV32I instruction fetch stage
// Purpose: owns the PC, issues in-order word fetches under a credit limit,
// buffers responses in fetch_fifo and presents them to decode. A redirect
// clears the buffer and marks every outstanding response for discard.
// Optional macro IF_BYPASS_EN: a response arriving while the buffer is empty
// goes straight to decode in the same cycle.
// Ports:
//   clk_i, rst_i                         clock, asynchronous active-high reset
//   imem_req_o, imem_addr_o, imem_gnt_i  fetch request handshake
//   imem_rvalid_i, imem_rdata_i          in-order fetch responses
//   redirect_i, redirect_pc_i            taken branch / PC redirect
//   id_valid_o, id_ready_i               decode handshake
//   id_instr_o, id_pc_o                  instruction and its address
module if_stage
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            id_valid_o,
   input  logic            id_ready_i,
   output logic [XLEN-1:0] id_instr_o,
   output logic [XLEN-1:0] id_pc_o
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;
   localparam int SW = CW + 2;

   logic [XLEN-1:0]   pc;
   logic [CW-1:0]     inflight;
   logic [CW-1:0]     drop;
   logic [CW-1:0]     fifo_count;
   logic [2*XLEN-1:0] fifo_head;
   logic [XLEN-1:0]   resp_pc;
   logic [SW-1:0]     credit_used;
   logic              fifo_empty;
   logic              fifo_push;
   logic              fifo_pop;
   logic              grant;
   logic              resp_keep;
   logic              resp_drop;

   assign fifo_empty = (fifo_count == '0);
   assign resp_drop  = imem_rvalid_i && (drop != '0);
   assign resp_keep  = imem_rvalid_i && (drop == '0);

   // Kept requests since the last redirect are consecutive words, so the
   // oldest one answering now sits inflight words behind the PC.
   assign resp_pc = pc - (XLEN'(inflight) << 2);

   assign fifo_pop = id_valid_o && id_ready_i && !fifo_empty;

   // Every outstanding or buffered word holds a slot; a word leaving to
   // decode this cycle frees its slot for a new request.
   assign credit_used = SW'(inflight) + SW'(drop) + SW'(fifo_count) - SW'(fifo_pop);

   assign imem_req_o  = !rst_i && !redirect_i && (credit_used < SW'(BUF_DEPTH));
   assign imem_addr_o = pc;
   assign grant       = imem_req_o && imem_gnt_i;

`ifdef IF_BYPASS_EN
   logic bypass;

   assign bypass    = resp_keep && fifo_empty && !redirect_i;
   assign fifo_push = resp_keep && !redirect_i && !(bypass && id_ready_i);

   always_comb begin
      id_valid_o = 1'b0;
      id_instr_o = NOP_INSTR;
      id_pc_o    = '0;
      if (!fifo_empty) begin
         id_valid_o = !redirect_i;
         id_instr_o = fifo_head[XLEN-1:0];
         id_pc_o    = fifo_head[2*XLEN-1:XLEN];
      end else if (bypass) begin
         id_valid_o = 1'b1;
         id_instr_o = imem_rdata_i;
         id_pc_o    = resp_pc;
      end
   end
`else
   assign fifo_push = resp_keep && !redirect_i;

   always_comb begin
      id_valid_o = 1'b0;
      id_instr_o = NOP_INSTR;
      id_pc_o    = '0;
      if (!fifo_empty) begin
         id_valid_o = !redirect_i;
         id_instr_o = fifo_head[XLEN-1:0];
         id_pc_o    = fifo_head[2*XLEN-1:XLEN];
      end
   end
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc       <= RESET_PC;
         inflight <= '0;
         drop     <= '0;
      end else if (redirect_i) begin
         pc       <= {redirect_pc_i[XLEN-1:2], 2'b00};
         inflight <= '0;
         // Everything still outstanding after this cycle is wrong-path;
         // a response arriving now is discarded too.
         drop     <= drop + inflight - CW'(imem_rvalid_i);
      end else begin
         if (grant) pc <= pc + 32'd4;
         inflight <= inflight + CW'(grant) - CW'(resp_keep);
         drop     <= drop - CW'(resp_drop);
      end
   end

   fetch_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (2*XLEN)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (redirect_i),
      .push_i      (fifo_push),
      .push_data_i ({resp_pc, imem_rdata_i}),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .count_o     (fifo_count)
   );

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage
module tb_if_stage;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int          BUF_DEPTH = 2;
   localparam logic [31:0] NOP       = 32'h0000_0013;
`ifdef IF_BYPASS_EN
   localparam int FIRST_VALID = 1;
`else
   localparam int FIRST_VALID = 2;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i = 1'b0;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = '0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        id_valid_o;
   logic        id_ready_i = 1'b0;
   logic [31:0] id_instr_o;
   logic [31:0] id_pc_o;

   if_stage #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .id_valid_o    (id_valid_o),
      .id_ready_i    (id_ready_i),
      .id_instr_o    (id_instr_o),
      .id_pc_o       (id_pc_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] due;
   } mreq_t;

   typedef struct {
      logic [31:0] target;
      logic [31:0] addr0;
      logic [31:0] addr1;
   } redir_vec_t;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   int          decoded = 0;
   mreq_t       mq[$];
   logic [31:0] exp_pc = RESET_PC;
   logic        s_req, s_valid;
   logic [31:0] s_addr, s_pc, s_instr;
   redir_vec_t  vecs[4];
   logic        b_req[8], b_valid[8];
   logic [31:0] b_addr[8], b_pc[8];
   logic [31:0] hold_pc, hold_instr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   // One clock cycle: memory model drives responses, outputs are sampled at
   // the falling edge, and the decoded stream is scored against the
   // sequential-from-last-target rule.
   task automatic step(input bit gnt, input int lat, input bit rdy, input bit redir,
                       input logic [31:0] tgt);
      imem_gnt_i    = gnt;
      id_ready_i    = rdy;
      redirect_i    = redir;
      redirect_pc_i = tgt;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = mem_word(mq[0].addr);
         void'(mq.pop_front());
      end else begin
         imem_rvalid_i = 1'b0;
         imem_rdata_i  = $urandom;
      end
      @(negedge clk);
      s_req   = imem_req_o;
      s_addr  = imem_addr_o;
      s_valid = id_valid_o;
      s_pc    = id_pc_o;
      s_instr = id_instr_o;
      if (rst) begin
         mq.delete();
         exp_pc = RESET_PC;
      end else begin
         if (s_req && gnt) mq.push_back('{addr: s_addr, due: 32'(cyc + 1 + lat)});
         if (redir) begin
            chk("redir_no_valid", 32'(s_valid), 32'd0);
            chk("redir_no_req", 32'(s_req), 32'd0);
            exp_pc = {tgt[31:2], 2'b00};
         end else if (s_valid && rdy) begin
            chk("dec_pc", s_pc, exp_pc);
            chk("dec_instr", s_instr, mem_word(s_pc));
            exp_pc = exp_pc + 32'd4;
            decoded++;
         end
         chk("outstanding_le_depth", 32'(mq.size() <= BUF_DEPTH), 32'd1);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_first(input logic [31:0] exp, input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step(1'b1, 0, 1'b1, 1'b0, 32'h0);
         if (s_valid) seen = 1'b1;
      end
      chk({name, "_seen"}, 32'(seen), 32'd1);
      chk(name, s_pc, exp);
   endtask

   task automatic drain();
      for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b1, 1'b0, 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int d0;
      vecs[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
      vecs[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
      vecs[2] = '{32'h0000_0002, 32'h0000_0000, 32'h0000_0004};
      vecs[3] = '{32'h8000_0001, 32'h8000_0000, 32'h8000_0004};

      // Reset state
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_req", 32'(imem_req_o), 32'd0);
      chk("rst_addr", imem_addr_o, RESET_PC);
      chk("rst_valid", 32'(id_valid_o), 32'd0);
      chk("rst_instr", id_instr_o, NOP);
      chk("rst_pc", id_pc_o, 32'd0);
      step(1'b0, 0, 1'b1, 1'b0, 32'h0);
      rst = 1'b0;

      // Back-to-back fetch with 1-cycle memory
      for (int c = 0; c < 8; c++) begin
         step(1'b1, 0, 1'b1, 1'b0, 32'h0);
         b_req[c] = s_req; b_addr[c] = s_addr; b_valid[c] = s_valid; b_pc[c] = s_pc;
      end
      for (int c = 0; c < 5; c++) begin
         chk("b2b_req", 32'(b_req[c]), 32'd1);
         chk("b2b_addr", b_addr[c], 32'(4 * c));
      end
      chk("first_valid_latency", 32'(b_valid[FIRST_VALID-1]), 32'd0);
      for (int k = 0; k < 4; k++) begin
         chk("stream_valid", 32'(b_valid[FIRST_VALID+k]), 32'd1);
         chk("stream_pc", b_pc[FIRST_VALID+k], 32'(4 * k));
      end

      // Decode stall for 10 cycles
      for (int s = 0; s < 10; s++) begin
         step(1'b1, 0, 1'b0, 1'b0, 32'h0);
         if (s == 2) begin
            hold_pc = s_pc;
            hold_instr = s_instr;
         end
      end
      chk("stall_req_off", 32'(s_req), 32'd0);
      chk("stall_valid", 32'(s_valid), 32'd1);
      chk("stall_pc_stable", s_pc, hold_pc);
      chk("stall_instr_stable", s_instr, hold_instr);
      for (int i = 0; i < 6; i++) step(1'b1, 0, 1'b1, 1'b0, 32'h0);

      // Redirect with slow responses in flight
      for (int i = 0; i < 3; i++) step(1'b1, 3, 1'b1, 1'b0, 32'h0);
      chk("inflight_before_redir", 32'(mq.size()), 32'(BUF_DEPTH));
      step(1'b1, 3, 1'b1, 1'b1, 32'h0000_0100);
      wait_first(32'h0000_0100, "redir_target");

      // Redirect alongside a response, then a second redirect
      for (int i = 0; i < 3; i++) step(1'b1, 0, 1'b1, 1'b0, 32'h0);
      step(1'b1, 0, 1'b1, 1'b1, 32'h0000_0300);
      step(1'b1, 0, 1'b1, 1'b1, 32'h0000_0200);
      wait_first(32'h0000_0200, "double_redir");

      // Redirect target alignment and PC wrap
      for (int v = 0; v < 4; v++) begin
         drain();
         step(1'b0, 0, 1'b1, 1'b1, vecs[v].target);
         step(1'b0, 0, 1'b1, 1'b0, 32'h0);
         chk("vec_req", 32'(s_req), 32'd1);
         chk("vec_addr0", s_addr, vecs[v].addr0);
         step(1'b1, 0, 1'b1, 1'b0, 32'h0);
         step(1'b0, 0, 1'b1, 1'b0, 32'h0);
         chk("vec_addr1", s_addr, vecs[v].addr1);
      end

      // Randomized traffic
      d0 = decoded;
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] tgt;
         tgt = $urandom;
         if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
         step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
              $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, tgt);
      end
      chk("random_progress", 32'(decoded - d0 > 300), 32'd1);

      // Reset in the middle of traffic
      for (int i = 0; i < 4; i++) step(1'b1, 1, 1'b1, 1'b0, 32'h0);
      rst = 1'b1;
      step(1'b1, 0, 1'b1, 1'b0, 32'h0);
      chk("midrst_req", 32'(s_req), 32'd0);
      chk("midrst_valid", 32'(s_valid), 32'd0);
      chk("midrst_addr", s_addr, RESET_PC);
      rst = 1'b0;
      wait_first(RESET_PC, "midrst_first_pc");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
